serial_add_sched: RTL
=====================

# serial_add_sched

Round-robin scheduler that shares one serial adder datapath (the PISO/full-adder/SIPO/FSM chain) between `NUM_REQ` requesters. It arbitrates requests and captures the winner's operands. It then pulses the adder's start and waits for the adder's completion, applying a watchdog timeout. Finally it returns the `WIDTH+1`-bit sum, tagged with the requester ID, over a valid/ready response port.

## Interface
- `WIDTH`, 8: operand width; the sum is `WIDTH+1` bits.
- `NUM_REQ`, 4: number of requesters, minimum 2.
- `TIMEOUT`, `WIDTH+4`: maximum number of WAIT cycles before the operation is aborted.
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_i`  in  `NUM_REQ`  per-requester request level; held until granted.
- `a_i`  in  `NUM_REQ*WIDTH`  operand A; requester k uses `[k*WIDTH +: WIDTH]`.
- `b_i`  in  `NUM_REQ*WIDTH`  operand B; same packing as `a_i`.
- `gnt_o`  out  `NUM_REQ`  one-hot, single-cycle grant pulse.
- `busy_o`  out  1  high in every state except IDLE.
- `add_start_o`  out  1  single-cycle start pulse to the adder.
- `add_a_o`, `add_b_o`  out  `WIDTH`  captured operands; stable from LAUNCH through RESP.
- `add_sum_i`  in  `WIDTH+1`  adder result; valid in the `add_done_i` cycle.
- `add_done_i`  in  1  adder completion strobe.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_id_o`  out  `$clog2(NUM_REQ)`  index of the requester that is served.
- `rsp_sum_o`  out  `WIDTH+1`  `{carry, sum}`.
- `rsp_err_o`  out  1  timeout flag; when set, `rsp_sum_o` = 0.

## Operation
- **States:** IDLE, LAUNCH, WAIT, RESP, held in a registered state machine.
- **IDLE:** if `req_i` is nonzero, select a winner by round-robin.
  - Search starts at `ptr` and proceeds upward, wrapping from `NUM_REQ-1` to 0.
  - In the same cycle: drive `gnt_o[win]`=1, capture `a_i`/`b_i` slices and `win` into registers, set `ptr` = win+1 (mod `NUM_REQ`), go to LAUNCH.
  - If `req_i` is zero, stay in IDLE.
- **LAUNCH:** `add_start_o`=1 for exactly one cycle; clear the timer; go to WAIT.
- **WAIT:** the timer increments each cycle.
  - If `add_done_i`=1: register `add_sum_i` into `rsp_sum_o`, set `rsp_err_o`=0, go to RESP.
  - Else if timer == `TIMEOUT-1`: set `rsp_sum_o`=0 and `rsp_err_o`=1, go to RESP.
  - If done and timeout fall in the same cycle, done wins.
- **RESP:** `rsp_valid_o`=1; `rsp_id_o`, `rsp_sum_o` and `rsp_err_o` are held stable.
  - On `rsp_valid_o && rsp_ready_i`, go to IDLE.
  - While `rsp_ready_i`=0, stay in RESP indefinitely.
- **Stray done:** `add_done_i` outside WAIT is ignored.
- **No preemption:** requests arriving during an operation wait in `req_i`.
- **Arithmetic:** the block performs none; `add_sum_i` is passed through unmodified.

## Timing
- **Reset:** `reset_i` high at a clock edge forces the following, regardless of state (including mid-WAIT or mid-RESP):
  - state=IDLE, `ptr`=0, timer=0;
  - all outputs 0: `gnt_o`, `busy_o`, `add_start_o`, `add_a_o`, `add_b_o`, `rsp_valid_o`, `rsp_id_o`, `rsp_sum_o`, `rsp_err_o`;
  - an in-flight response is dropped;
  - the adder is not reset by this block.
- **Latency:**
  - grant at cycle T;
  - `add_start_o` at T+1;
  - `add_done_i` at T+1+L;
  - `rsp_valid_o` at T+2+L.
  - For the 8-bit adder, L = `WIDTH+1` = 9 cycles.
- **Timeout:** `rsp_valid_o` with `rsp_err_o`=1 at T+2+`TIMEOUT`.
- **Back-to-back:** the handshake cycle in RESP returns to IDLE at the next edge. The earliest next grant is that IDLE cycle.
- **Grant spacing:** minimum grant-to-grant spacing is L+3 cycles.
- **Operand stability:** `add_a_o`/`add_b_o` do not change between LAUNCH and the next grant.

## Test plan
- **Single request:** req_i=4'b0100, a=8'hFF, b=8'h01, adder model L=9. Expect:
  - `gnt_o`=4'b0100 for one cycle;
  - one `add_start_o` pulse;
  - `rsp_valid_o` 11 cycles after grant, with id=2, sum=9'h100, err=0.
- **Fairness:** req_i=4'b1111 held, rsp_ready_i=1. Expect grants in order 0,1,2,3,0, and `rsp_id_o` sequence 0,1,2,3,0.
- **Timeout:** `add_done_i` never asserts. Expect:
  - `rsp_valid_o` at T+2+`TIMEOUT` (T+14);
  - `rsp_err_o`=1, `rsp_sum_o`=0;
  - next grant proceeds normally.
- **Backpressure:** rsp_ready_i=0 for 5 cycles after valid. Expect:
  - valid, id and sum held stable;
  - no new grant despite req_i=4'b0011;
  - handshake on the 6th cycle.
- **Reset mid-operation:** assert reset_i during WAIT. Expect:
  - next cycle: all outputs 0, state IDLE;
  - a later `add_done_i` is ignored;
  - subsequent req_i=4'b1000 is granted to requester 3, with search starting at ptr=0.
- **Collision:** `add_done_i` exactly at timer == `TIMEOUT-1`. Expect `rsp_err_o`=0 and `rsp_sum_o` = `add_sum_i`.

Source files
------------

// File: rtl/serial_add_sched_if.sv
// serial_add_sched_if: bundles the request, adder-control and response
// signals of the serial adder scheduler.
//   slave  - the scheduler side (takes requests, drives the adder, answers)
//   master - the requester / adder / response-consumer side
interface serial_add_sched_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] a_i;
  logic [NUM_REQ*WIDTH-1:0] b_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     busy_o;
  logic                     add_start_o;
  logic [WIDTH-1:0]         add_a_o;
  logic [WIDTH-1:0]         add_b_o;
  logic [WIDTH:0]           add_sum_i;
  logic                     add_done_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [IDW-1:0]           rsp_id_o;
  logic [WIDTH:0]           rsp_sum_o;
  logic                     rsp_err_o;

  modport slave (
    input  req_i, a_i, b_i, add_sum_i, add_done_i, rsp_ready_i,
    output gnt_o, busy_o, add_start_o, add_a_o, add_b_o,
           rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_err_o
  );

  modport master (
    output req_i, a_i, b_i, add_sum_i, add_done_i, rsp_ready_i,
    input  gnt_o, busy_o, add_start_o, add_a_o, add_b_o,
           rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_err_o
  );
endinterface

// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler sharing one serial adder among
// NUM_REQ requesters. Grants a requester, captures its operands, starts the
// adder, waits for completion under a watchdog, then returns the tagged sum
// over a valid/ready response port.
// Ports:
//   clk_i   - single clock, rising edge
//   reset_i - synchronous active-high reset
//   bus     - serial_add_sched_if.slave (requests, adder control, response)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no operation; round-robin pick among pending requests
// S_LAUNCH | operands captured, start pulse to adder, timer cleared
// S_WAIT   | waiting for add_done_i, watchdog timer running
// S_RESP   | response valid, held until rsp_ready_i
module serial_add_sched #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = WIDTH + 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  serial_add_sched_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [TW-1:0]   timer;
  logic [IDW-1:0]  win;
  logic            found;

  // Round-robin pick: first requester at or above ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_i[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  // The grant has to appear in the same cycle the IDLE decision is made,
  // so it is decoded from the state register rather than registered itself.
  assign bus.gnt_o = (state == S_IDLE && found && !reset_i)
                     ? (NUM_REQ'(1) << win) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= S_IDLE;
      ptr             <= '0;
      timer           <= '0;
      bus.busy_o      <= 1'b0;
      bus.add_start_o <= 1'b0;
      bus.add_a_o     <= '0;
      bus.add_b_o     <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_id_o    <= '0;
      bus.rsp_sum_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      bus.add_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            bus.add_a_o     <= bus.a_i[int'(win)*WIDTH +: WIDTH];
            bus.add_b_o     <= bus.b_i[int'(win)*WIDTH +: WIDTH];
            bus.rsp_id_o    <= win;
            ptr             <= (win == IDW'(NUM_REQ-1)) ? '0 : win + IDW'(1);
            bus.add_start_o <= 1'b1;
            bus.busy_o      <= 1'b1;
            state           <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          // done takes priority over a coincident timeout
          if (bus.add_done_i) begin
            bus.rsp_sum_o   <= bus.add_sum_i;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            state           <= S_RESP;
          end else if (timer == TW'(TIMEOUT-1)) begin
            bus.rsp_sum_o   <= '0;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_valid_o <= 1'b1;
            state           <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.busy_o      <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
